serial_pattern_tx: RTL and testbench

- Bit-serial transmitter: the sending end of the serial stream our sequence detector consumes.
- Accepts parallel words over a valid/ready handshake and emits each one MSB-first on a single-bit line, one bit per slow bit period.
- Each word can be preceded by the detector's match pattern as a frame header.
- Bit pacing is a clock-enable from a divider, never a derived clock; the whole block runs on `clk`.

---
 rtl/serial_pattern_tx_pkg.sv | 20 ++
 rtl/serial_pattern_tx_if.sv | 11 +
 rtl/serial_pattern_tx_bit_tick_gen.sv | 29 ++
 rtl/serial_pattern_tx.sv | 101 ++++++++++
 tb/tb_serial_pattern_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its sequence detector.
// Both ends import the header defaults from here so they always agree.
package seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } tx_state_e;

  localparam int SEQ_WIDTH_DEF = 4;
  localparam logic [SEQ_WIDTH_DEF-1:0] MATCH_SEQ_DEF = 4'b1001;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/serial_pattern_tx_if.sv
// Parallel word handshake into the serial transmitter.
interface serial_pattern_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/serial_pattern_tx_bit_tick_gen.sv
// Bit-period clock enable: tick is high for one cycle every DIVISOR enabled cycles.
// pre_tick flags the cycle before a tick so callers can register tick-aligned outputs.
module bit_tick_gen
  import seq_pkg::*;
#(
  parameter int DIVISOR = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = clog2_min1(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] PRE  = CW'((DIVISOR > 1) ? DIVISOR - 2 : 0);

  logic [CW-1:0] r_cnt;

  assign tick     = enable && (r_cnt == LAST);
  assign pre_tick = (DIVISOR > 1) && enable && (r_cnt == PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_cnt <= '0;
    else if (clear || tick || !enable) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/serial_pattern_tx.sv
// Bit-serial transmitter: optional MATCH_SEQ header, then the payload word MSB-first,
// each bit held for DIVISOR clk cycles. Supports back-to-back frames with no gap.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int                   DATA_WIDTH    = 8,
  parameter int                   SEQ_WIDTH     = SEQ_WIDTH_DEF,
  parameter logic [SEQ_WIDTH-1:0] MATCH_SEQ     = MATCH_SEQ_DEF,
  parameter bit                   INSERT_HEADER = 1'b1,
  parameter int                   DIVISOR       = 12_500_000,
  parameter bit                   IDLE_LEVEL    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_pattern_tx_if.slave tx_if,
  output logic               tx_stream,
  output logic               bit_strobe,
  output logic               frame_done,
  output logic               busy
);
  localparam int IW = clog2_min1(max_int(SEQ_WIDTH, DATA_WIDTH));
  localparam int HW = clog2_min1(SEQ_WIDTH);
  localparam logic [IW-1:0] HDR_TOP = IW'(SEQ_WIDTH - 1);
  localparam logic [IW-1:0] DAT_TOP = IW'(DATA_WIDTH - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_sh, w_sh_nxt;
  logic w_tick, w_pre_tick, w_accept, w_last;
  logic w_tx_nxt, w_strobe_nxt, w_done_nxt, w_busy_nxt;

  assign w_last         = (r_state == ST_DATA) && (r_idx == '0);
  assign tx_if.in_ready = (r_state == ST_IDLE) || (w_last && w_tick);
  assign w_accept       = tx_if.in_valid && tx_if.in_ready;

  bit_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (r_state != ST_IDLE),
    .clear    (w_accept),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    unique case (r_state)
      ST_HEADER: if (w_tick) begin
        if (r_idx == '0) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = DAT_TOP;
        end else w_idx_nxt = r_idx - 1'b1;
      end
      ST_DATA: if (w_tick) begin
        w_sh_nxt = r_sh << 1;
        if (r_idx == '0) w_state_nxt = ST_IDLE;
        else             w_idx_nxt   = r_idx - 1'b1;
      end
      default: ;
    endcase
    // Accept overrides the end-of-frame return to IDLE, giving gapless chaining.
    if (w_accept) begin
      w_sh_nxt    = tx_if.in_data;
      w_state_nxt = INSERT_HEADER ? ST_HEADER : ST_DATA;
      w_idx_nxt   = INSERT_HEADER ? HDR_TOP : DAT_TOP;
    end

    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_strobe_nxt = w_accept || (w_tick && w_busy_nxt);
    unique case (w_state_nxt)
      ST_HEADER: w_tx_nxt = MATCH_SEQ[w_idx_nxt[HW-1:0]];
      ST_DATA:   w_tx_nxt = w_sh_nxt[DATA_WIDTH-1];
      default:   w_tx_nxt = IDLE_LEVEL;
    endcase
    // frame_done is registered, so it is raised one cycle ahead of the final tick.
    w_done_nxt = (DIVISOR == 1) ? ((w_state_nxt == ST_DATA) && (w_idx_nxt == '0))
                                : (w_last && w_pre_tick);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_sh       <= '0;
      tx_stream  <= IDLE_LEVEL;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_sh       <= w_sh_nxt;
      tx_stream  <= w_tx_nxt;
      bit_strobe <= w_strobe_nxt;
      frame_done <= w_done_nxt;
      busy       <= w_busy_nxt;
    end
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a header/DIVISOR=4 instance and a no-header/DIVISOR=1
// instance, each checked every cycle against a frame-level expected-output queue.
module tb_serial_pattern_tx;
  import seq_pkg::*;

  localparam int DIV_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb;
  logic tx_a, stb_a, done_a, busy_a;
  logic tx_b, stb_b, done_b, busy_b;

  serial_pattern_tx_if #(.DATA_WIDTH(8)) ifa ();
  serial_pattern_tx_if #(.DATA_WIDTH(8)) ifb ();

  serial_pattern_tx #(
    .DATA_WIDTH(8), .SEQ_WIDTH(4), .MATCH_SEQ(4'b1001),
    .INSERT_HEADER(1'b1), .DIVISOR(DIV_A), .IDLE_LEVEL(1'b0)
  ) u_a (
    .clk(clk), .rst_n(rst_na), .tx_if(ifa),
    .tx_stream(tx_a), .bit_strobe(stb_a), .frame_done(done_a), .busy(busy_a)
  );

  serial_pattern_tx #(
    .DATA_WIDTH(8), .SEQ_WIDTH(4), .MATCH_SEQ(4'b1001),
    .INSERT_HEADER(1'b0), .DIVISOR(1), .IDLE_LEVEL(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_nb), .tx_if(ifb),
    .tx_stream(tx_b), .bit_strobe(stb_b), .frame_done(done_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs {tx, strobe, done, busy}; empty queue means idle.
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int acc_a = 0;
  int acc_b = 0;

  // Loopback detector: clocked by bit_strobe, looks for 1001 in the received bits.
  logic [3:0] det;
  int det_n, det_hits, det_at;

  function automatic void push_frame_a(input logic [7:0] w);
    logic [11:0] bits;
    bits = {4'b1001, w};
    for (int b = 11; b >= 0; b--)
      for (int c = 0; c < DIV_A; c++)
        qa.push_back({bits[b], (c == 0), (b == 0) && (c == DIV_A - 1), 1'b1});
  endfunction

  function automatic void push_frame_b(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) qb.push_back({w[b], 1'b1, (b == 0), 1'b1});
  endfunction

  task automatic cyc_a(input logic v, input logic [7:0] d);
    logic [3:0] e;
    logic r;
    e = (qa.size() > 0) ? qa[0] : 4'b0000;
    r = (qa.size() <= 1);
    chk("A outputs {tx,strobe,done,busy,ready}",
        {27'd0, tx_a, stb_a, done_a, busy_a, ifa.in_ready}, {27'd0, e, r});
    if (stb_a) begin
      det = {det[2:0], tx_a};
      det_n++;
      if (det == 4'b1001) begin det_hits++; det_at = det_n; end
    end
    ifa.in_valid = v;
    ifa.in_data  = d;
    @(posedge clk);
    if (qa.size() > 0) qa.delete(0);
    if (v && r) begin push_frame_a(d); acc_a++; end
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic v, input logic [7:0] d);
    logic [3:0] e;
    logic r;
    e = (qb.size() > 0) ? qb[0] : 4'b0000;
    r = (qb.size() <= 1);
    chk("B outputs {tx,strobe,done,busy,ready}",
        {27'd0, tx_b, stb_b, done_b, busy_b, ifb.in_ready}, {27'd0, e, r});
    ifb.in_valid = v;
    ifb.in_data  = d;
    @(posedge clk);
    if (qb.size() > 0) qb.delete(0);
    if (v && r) begin push_frame_b(d); acc_b++; end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
    int         exp_done;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] cap;
    logic [7:0]  capb;
    int nstb, dpos, nbusy, rises, chain, acc0;
    logic pbusy;

    tbl[0] = '{data: 8'h81, exp_bits: 8'b1000_0001, exp_done: 8};
    tbl[1] = '{data: 8'h00, exp_bits: 8'b0000_0000, exp_done: 8};
    tbl[2] = '{data: 8'hFF, exp_bits: 8'b1111_1111, exp_done: 8};
    tbl[3] = '{data: 8'h5A, exp_bits: 8'b0101_1010, exp_done: 8};
    tbl[4] = '{data: 8'h09, exp_bits: 8'b0000_1001, exp_done: 8};

    det = 4'b0; det_n = 0; det_hits = 0; det_at = 0;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00;
    rst_na = 1'b0; rst_nb = 1'b0;
    #12;
    chk("A reset state", {27'd0, tx_a, stb_a, done_a, busy_a, ifa.in_ready}, 32'b00001);
    chk("B reset state", {27'd0, tx_b, stb_b, done_b, busy_b, ifb.in_ready}, 32'b00001);
    @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1;
    repeat (2) cyc_a(1'b0, 8'h00);

    // Single word with header
    cap = '0; nstb = 0; dpos = 0;
    cyc_a(1'b1, 8'hA5);
    for (int i = 1; i <= 52; i++) begin
      if (stb_a) begin cap = {cap[10:0], tx_a}; nstb++; end
      if (done_a && dpos == 0) dpos = i;
      cyc_a(1'b0, 8'h00);
    end
    chk("A5 serial bits", {20'd0, cap}, {20'd0, 12'b1001_1010_0101});
    chk("A5 strobe count", nstb, 12);
    chk("A5 frame_done cycle", dpos, 48);

    // Back-to-back frames with in_valid held high
    acc0 = acc_a; nbusy = 0; rises = 0; chain = 0; pbusy = 1'b0;
    for (int i = 0; i < 112; i++) begin
      if (busy_a) nbusy++;
      if (busy_a && !pbusy) rises++;
      pbusy = busy_a;
      if (busy_a && ifa.in_ready) begin
        chk("frame_done with chaining ready", {31'd0, done_a}, 32'd1);
        if (acc_a == acc0 + 1) chain++;
      end
      cyc_a((acc_a - acc0) < 2, (i == 0) ? 8'hFF : 8'h00);
    end
    chk("b2b accepts", acc_a - acc0, 2);
    chk("b2b chained accept", chain, 1);
    chk("b2b busy cycles", nbusy, 96);
    chk("b2b busy rises", rises, 1);

    // Reset during payload bit 3, then a clean frame
    cyc_a(1'b1, 8'hA5);
    repeat (16 + 3 * DIV_A + 1) cyc_a(1'b0, 8'h00);
    chk("busy before mid-frame reset", {31'd0, busy_a}, 32'd1);
    #2 rst_na = 1'b0;
    #1;
    chk("A async reset outputs", {27'd0, tx_a, stb_a, done_a, busy_a, ifa.in_ready}, 32'b00001);
    qa.delete();
    @(negedge clk);
    chk("A held reset outputs", {27'd0, tx_a, stb_a, done_a, busy_a, ifa.in_ready}, 32'b00001);
    rst_na = 1'b1;
    cyc_a(1'b0, 8'h00);
    cap = '0; nstb = 0;
    cyc_a(1'b1, 8'h3C);
    for (int i = 0; i < 52; i++) begin
      if (stb_a) begin cap = {cap[10:0], tx_a}; nstb++; end
      cyc_a(1'b0, 8'h00);
    end
    chk("3C after reset bits", {20'd0, cap}, {20'd0, 12'b1001_0011_1100});
    chk("3C after reset strobes", nstb, 12);

    // Loopback into detector; in_valid pulsed while not ready must not transfer
    det = 4'b0; det_n = 0; det_hits = 0; det_at = 0; nstb = 0;
    cyc_a(1'b1, 8'h00);
    for (int i = 0; i < 60; i++) begin
      if (stb_a) nstb++;
      cyc_a((i >= 10 && i < 14), 8'hFF);
    end
    chk("loopback match count", det_hits, 1);
    chk("loopback match position", det_at, 4);
    chk("no transfer without ready", nstb, 12);

    // Random traffic on A
    for (int i = 0; i < 400; i++) cyc_a(($urandom_range(0, 7) == 0), 8'($urandom));
    repeat (50) cyc_a(1'b0, 8'h00);

    // Table vectors on B: header off, DIVISOR=1
    for (int k = 0; k < 5; k++) begin
      capb = '0; nstb = 0; dpos = 0;
      cyc_b(1'b1, tbl[k].data);
      for (int i = 1; i <= 10; i++) begin
        if (i <= 8) capb = {capb[6:0], tx_b};
        if (stb_b) nstb++;
        if (done_b && dpos == 0) dpos = i;
        cyc_b(1'b0, 8'h00);
      end
      chk($sformatf("B vec %0d bits", k), {24'd0, capb}, {24'd0, tbl[k].exp_bits});
      chk($sformatf("B vec %0d frame_done", k), dpos, tbl[k].exp_done);
      chk($sformatf("B vec %0d strobes", k), nstb, 8);
    end

    // Random traffic on B
    for (int i = 0; i < 300; i++) cyc_b(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (12) cyc_b(1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
